// File: rtl/tlp_fifo_pkg.sv
// Shared constants and control bundle for the TLP slice FIFO.
// Default geometry is 8 entries of 4-bit data slices.
package tlp_fifo_pkg;

    localparam int DATA_WIDTH_DEF      = 4;
    localparam int ADDR_WIDTH_DEF      = 3;
    localparam int DEPTH_DEF           = 2 ** ADDR_WIDTH_DEF;
    localparam int ALMOST_FULL_TH_DEF  = 6;
    localparam int ALMOST_EMPTY_TH_DEF = 2;

    typedef struct packed {
        logic push_ok;
        logic pop_ok;
        logic ovf;
        logic udf;
    } fifo_ctl_t;

endpackage

// File: rtl/tlp_fifo_mem.sv
// Register-array storage with a synchronous write port and a
// registered read port whose output clears on reset.
module tlp_fifo_mem
    import tlp_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Read samples the pre-write array, so a same-edge write to the
    // slot being read never leaks through.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tlp_fifo.sv
// Single-clock FIFO for TLP data slices: pointers, occupancy,
// flow-control flags and a sticky overflow/underflow error.
module tlp_fifo
    import tlp_fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int ALMOST_FULL_TH  = ALMOST_FULL_TH_DEF,
    parameter int ALMOST_EMPTY_TH = ALMOST_EMPTY_TH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  push,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_TH);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_TH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  error_q, error_d;
    fifo_ctl_t             ctl;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign error        = error_q;

    // A pop frees a slot in the same edge, so push is allowed when full.
    always_comb begin
        ctl.push_ok = push && (!full || pop);
        ctl.pop_ok  = pop && !empty;
        ctl.ovf     = push && full && !pop;
        ctl.udf     = pop && empty && !push;

        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(ctl.push_ok);
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(ctl.pop_ok);
        error_d  = error_q | ctl.ovf | ctl.udf;

        count_d = count_q;
        unique case ({ctl.push_ok, ctl.pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    tlp_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (ctl.push_ok),
        .waddr (wr_ptr_q),
        .wdata (data_a),
        .re    (ctl.pop_ok),
        .raddr (rd_ptr_q),
        .rdata (q_b)
    );

endmodule

// File: tb/tb_tlp_fifo.sv
// Bench for tlp_fifo: vector table, corner sequences and random
// traffic checked against a queue-based reference model.
module tb_tlp_fifo;

    logic       clk;
    logic       reset;
    logic [3:0] data_a;
    logic       push;
    logic       pop;
    logic [3:0] q_b;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       error;

    int n_tests;
    int n_fail;

    logic [3:0] mq[$];
    logic [3:0] m_qb;
    logic       m_err;

    typedef struct {
        logic       push;
        logic       pop;
        logic [3:0] data;
        logic [3:0] q;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       err;
    } vec_t;

    vec_t vecs[21];

    tlp_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .data_a       (data_a),
        .push         (push),
        .pop          (pop),
        .q_b          (q_b),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] dut_v();
        return {q_b, full, empty, almost_full, almost_empty, error};
    endfunction

    function automatic logic [8:0] mdl_v();
        int sz;
        sz = mq.size();
        return {m_qb, sz == 8, sz == 0, sz >= 6, sz <= 2, m_err};
    endfunction

    task automatic check(input string nm, input logic [8:0] act,
                         input logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (q,full,empty,af,ae,err)",
                     nm, act, exp);
        end
    endtask

    task automatic mdl_reset();
        mq.delete();
        m_qb  = 4'h0;
        m_err = 1'b0;
    endtask

    task automatic do_reset();
        push   = 1'b0;
        pop    = 1'b0;
        data_a = 4'h0;
        reset  = 1'b1;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", dut_v(), 9'b0000_0_1_0_1_0);
        reset = 1'b0;
    endtask

    task automatic step(input logic p, input logic o, input logic [3:0] d,
                        input string nm);
        int sz;
        push   = p;
        pop    = o;
        data_a = d;
        sz = mq.size();
        if ((p && sz == 8 && !o) || (o && sz == 0 && !p)) m_err = 1'b1;
        if (o && sz > 0) m_qb = mq.pop_front();
        if (p && (sz < 8 || o)) mq.push_back(d);
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        check(nm, dut_v(), mdl_v());
    endtask

    function automatic vec_t mk(input logic p, input logic o,
                                input logic [3:0] d, input logic [3:0] q,
                                input logic f, input logic e, input logic af,
                                input logic ae, input logic er);
        vec_t v;
        v.push = p; v.pop = o; v.data = d; v.q = q;
        v.full = f; v.empty = e; v.af = af; v.ae = ae; v.err = er;
        return v;
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        data_a  = 4'h0;

        // fill 0..7, full push+pop, drain, empty push+pop, underflow
        vecs[0]  = mk(1, 0, 4'h0, 4'h0, 0, 0, 0, 1, 0);
        vecs[1]  = mk(1, 0, 4'h1, 4'h0, 0, 0, 0, 1, 0);
        vecs[2]  = mk(1, 0, 4'h2, 4'h0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 4'h3, 4'h0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 4'h4, 4'h0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 0, 4'h5, 4'h0, 0, 0, 1, 0, 0);
        vecs[6]  = mk(1, 0, 4'h6, 4'h0, 0, 0, 1, 0, 0);
        vecs[7]  = mk(1, 0, 4'h7, 4'h0, 1, 0, 1, 0, 0);
        vecs[8]  = mk(1, 1, 4'h9, 4'h0, 1, 0, 1, 0, 0);
        vecs[9]  = mk(0, 1, 4'h0, 4'h1, 0, 0, 1, 0, 0);
        vecs[10] = mk(0, 1, 4'h0, 4'h2, 0, 0, 1, 0, 0);
        vecs[11] = mk(0, 1, 4'h0, 4'h3, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 1, 4'h0, 4'h4, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 1, 4'h0, 4'h5, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 1, 4'h0, 4'h6, 0, 0, 0, 1, 0);
        vecs[15] = mk(0, 1, 4'h0, 4'h7, 0, 0, 0, 1, 0);
        vecs[16] = mk(0, 1, 4'h0, 4'h9, 0, 1, 0, 1, 0);
        vecs[17] = mk(1, 1, 4'hA, 4'h9, 0, 0, 0, 1, 0);
        vecs[18] = mk(0, 1, 4'h0, 4'hA, 0, 1, 0, 1, 0);
        vecs[19] = mk(0, 1, 4'h0, 4'hA, 0, 1, 0, 1, 1);
        vecs[20] = mk(1, 0, 4'h3, 4'hA, 0, 0, 0, 1, 1);

        do_reset();
        for (int i = 0; i < 21; i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].data, "vec_mdl");
            check($sformatf("vec%0d", i), dut_v(),
                  {vecs[i].q, vecs[i].full, vecs[i].empty,
                   vecs[i].af, vecs[i].ae, vecs[i].err});
        end

        // overflow: ninth push dropped, contents intact
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 4'(i), "ovf_fill");
        step(1, 0, 4'hF, "ovf_push");
        check("ovf_err", {8'h0, error}, 9'd1);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 4'h0, "ovf_drain");
            check("ovf_data", {5'h0, q_b}, 9'(i));
        end
        step(0, 0, 4'h0, "ovf_sticky");

        // underflow from reset
        do_reset();
        step(0, 1, 4'h0, "udf");
        check("udf_err", {error, q_b, 4'h0}, 9'b1_0000_0000);

        // streaming with overlap
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 4'(i), "str_fill");
        for (int i = 5; i < 8; i++) step(1, 1, 4'(i), "str_ovl");
        for (int i = 0; i < 6; i++) step(0, 1, 4'h0, "str_drain");

        // asynchronous reset mid-cycle
        do_reset();
        step(1, 0, 4'h5, "ar_push");
        step(1, 0, 4'h6, "ar_push");
        step(0, 1, 4'h0, "ar_pop");
        #2;
        reset = 1'b1;
        mdl_reset();
        #1;
        check("async_rst", dut_v(), 9'b0000_0_1_0_1_0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1, 0, 4'hC, "ar_repush");
        step(0, 1, 4'h0, "ar_repop");
        check("ar_first", {5'h0, q_b}, 9'h00C);

        // random traffic in biased phases, one reset mid-run
        do_reset();
        for (int k = 0; k < 12; k++) begin
            int pp;
            pp = (k % 3 == 0) ? 80 : ((k % 3 == 1) ? 20 : 50);
            if (k == 6) do_reset();
            for (int c = 0; c < 40; c++) begin
                step($urandom_range(99) < pp,
                     $urandom_range(99) < (100 - pp),
                     4'($urandom_range(15)), "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
